// File: rtl/note_slot_scheduler.sv
// note_slot_scheduler: owns the on-screen note pool for the Guitar Hero display.
// Fetches one lane mask per beat from the chart RAM, allocates one slot per set lane,
// advances live slots every frame, retires slots that leave the screen and resolves
// player hit strobes against the Y hit window.
// Optional feature macro: NOTE_SCHED_MISS_EN (miss pulse plus saturating miss counter).
module note_slot_scheduler #(
    parameter int SLOTS     = 16,
    parameter int YW        = 10,
    parameter int CHART_LEN = 64,
    parameter int SPAWN_Y   = 0,
    parameter int HEIGHT    = 480,
    parameter int SPEED     = 2,
    parameter int HIT_Y_MIN = 380,
    parameter int HIT_Y_MAX = 430,
    localparam int AW       = $clog2(CHART_LEN)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                frame_tick,
    input  logic                spawn_tick,
    output logic [AW-1:0]       chart_addr,
    input  logic [3:0]          chart_data,
    input  logic                hit_req,
    input  logic [1:0]          hit_lane,
    output logic                hit_ok,
    output logic                hit_bad,
    output logic [SLOTS-1:0]    slot_valid,
    output logic [2*SLOTS-1:0]  slot_lane,
    output logic [YW*SLOTS-1:0] slot_y,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                miss,
    output logic [7:0]          miss_count
);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(CHART_LEN - 1);
    localparam logic [YW:0]   HEIGHT_C  = (YW+1)'(HEIGHT);
    localparam logic [YW:0]   SPEED_C   = (YW+1)'(SPEED);
    localparam logic [YW-1:0] SPAWN_C   = YW'(SPAWN_Y);
    localparam logic [YW-1:0] HIT_MIN_C = YW'(HIT_Y_MIN);
    localparam logic [YW-1:0] HIT_MAX_C = YW'(HIT_Y_MAX);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FETCH, S_WAIT, S_ALLOC, S_DONE} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   addr_q;
    logic [3:0]      mask_q, mask_rest;
    logic [1:0]      cur_lane;
    logic [SLOTS-1:0] valid_q;
    logic [1:0]      lane_q [SLOTS];
    logic [YW-1:0]   y_q    [SLOTS];
    logic [YW:0]     moved  [SLOTS];
    logic            free_found, hit_found, hit_clr, alloc_en;
    logic [SW-1:0]   free_idx, hit_idx;

    // Lowest free slot, lowest slot in the hit window, moved Y per slot, next pending lane.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        hit_found  = 1'b0;
        hit_idx    = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
            if (valid_q[i] && lane_q[i] == hit_lane &&
                y_q[i] >= HIT_MIN_C && y_q[i] <= HIT_MAX_C) begin
                hit_found = 1'b1;
                hit_idx   = SW'(i);
            end
            moved[i] = {1'b0, y_q[i]} + SPEED_C;
        end
        cur_lane = 2'd0;
        for (int l = 3; l >= 0; l--)
            if (mask_q[l]) cur_lane = 2'(l);
        mask_rest = mask_q & (mask_q - 4'd1);
    end

    assign hit_clr  = hit_req && hit_found;
    assign alloc_en = (state == S_ALLOC) && !start && (mask_q != 4'd0);

    // Next-state logic; start restarts the chart from any state.
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (spawn_tick) state_nx = S_FETCH;
                S_FETCH: state_nx = S_WAIT;
                S_WAIT:  state_nx = S_ALLOC;
                S_ALLOC: if (mask_rest == 4'd0)
                             state_nx = (addr_q == LAST_ADDR) ? S_DONE : S_RUN;
                default: ;
            endcase
        end
    end

    // State register, chart address, latched lane mask and sticky overflow.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            mask_q   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                addr_q   <= '0;
                mask_q   <= '0;
                overflow <= 1'b0;
            end else begin
                if (state == S_WAIT) mask_q <= chart_data;
                if (state == S_ALLOC) begin
                    mask_q <= mask_rest;
                    if (mask_rest == 4'd0 && addr_q != LAST_ADDR) addr_q <= addr_q + AW'(1);
                    if (mask_q != 4'd0 && !free_found) overflow <= 1'b1;
                end
                if (spawn_tick && state != S_RUN) overflow <= 1'b1;
            end
        end
    end

    // Slot pool: hit clear beats retire beats move; allocation only targets currently free slots.
    // NOTE: the pool is reset explicitly because downstream logic reads lane/Y of every slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                lane_q[i] <= 2'd0;
                y_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (hit_clr && hit_idx == SW'(i)) begin
                    valid_q[i] <= 1'b0;
                end else if (frame_tick && valid_q[i]) begin
                    y_q[i] <= moved[i][YW-1:0];
                    if (moved[i] >= HEIGHT_C) valid_q[i] <= 1'b0;
                end
            end
            if (alloc_en && free_found) begin
                valid_q[free_idx] <= 1'b1;
                lane_q[free_idx]  <= cur_lane;
                y_q[free_idx]     <= SPAWN_C;
            end
        end
    end

    // Hit result pulses, one cycle after the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_ok  <= 1'b0;
            hit_bad <= 1'b0;
        end else begin
            hit_ok  <= hit_req && hit_found;
            hit_bad <= hit_req && !hit_found;
        end
    end

`ifdef NOTE_SCHED_MISS_EN
    localparam int CW = $clog2(SLOTS + 1);
    logic [CW-1:0] retire_cnt;
    logic [8:0]    miss_sum;
    logic          miss_q;
    logic [7:0]    miss_cnt_q;

    // Count slots leaving the screen this cycle that a hit did not claim.
    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < SLOTS; i++)
            if (frame_tick && valid_q[i] && moved[i] >= HEIGHT_C &&
                !(hit_clr && hit_idx == SW'(i)))
                retire_cnt = retire_cnt + CW'(1);
        miss_sum = {1'b0, miss_cnt_q} + 9'(retire_cnt);
    end

    // Single miss pulse per frame and saturating miss counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_q     <= 1'b0;
            miss_cnt_q <= 8'd0;
        end else begin
            miss_q     <= (retire_cnt != '0);
            miss_cnt_q <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
        end
    end

    assign miss       = miss_q;
    assign miss_count = miss_cnt_q;
`else
    assign miss       = 1'b0;
    assign miss_count = 8'd0;
`endif

    // Pack slot state for the VGA stage.
    always_comb begin
        slot_lane = '0;
        slot_y    = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_lane[2*i +: 2] = lane_q[i];
            slot_y[YW*i +: YW]  = y_q[i];
        end
    end

    assign slot_valid = valid_q;
    assign chart_addr = addr_q;
    assign busy       = (state == S_FETCH) || (state == S_WAIT) || (state == S_ALLOC);
    assign done       = (state == S_DONE);
endmodule
